// File: rtl/onchip_mem_arbiter.sv
// ============================================================================
// Module   : onchip_mem_arbiter
// Purpose  : Two-master Avalon-MM arbiter in front of port s1 of the
//            2048x32 on-chip memory. It grants one single-word read or
//            write at a time, drives registered memory commands and
//            returns read data to the granted master with a
//            readdatavalid strobe.
// Options  : ARB_M0_PRIORITY_EN - when defined, m0 always wins a tie
//            (fixed priority). When undefined, ties alternate
//            (round-robin on the last grant).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module onchip_mem_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  // master 0
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  // master 1
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  // memory port s1
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic   owner_q;     // 0 = m0 holds the memory, 1 = m1
  logic   is_rd_q;     // granted command is a read
  logic   req0;
  logic   req1;
  logic   any_req;
  logic   winner;
  logic   take;        // latch a new command this cycle

`ifndef ARB_M0_PRIORITY_EN
  logic   last_grant_q;
`endif

  // Request decode: a master requests when it asserts read or write.
  always_comb begin
    req0    = m0_read | m0_write;
    req1    = m1_read | m1_write;
    any_req = req0 | req1;
    take    = (state_q == IDLE) && any_req;
  end

  // Winner selection; a lone requester always wins, ties depend on the build.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
`ifdef ARB_M0_PRIORITY_EN
      winner = 1'b0;
`else
      winner = ~last_grant_q;
`endif
    end else if (req1) begin
      winner = 1'b1;
    end
  end

  // Next-state logic: arbitration only happens from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = is_rd_q ? RDATA : IDLE;
      RDATA:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any outstanding read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command capture: the winner's command is frozen here, so a master that
  // drops its request after this point still gets its transfer executed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q        <= 1'b0;
      is_rd_q        <= 1'b0;
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_writedata  <= '0;
    end else if (take) begin
      owner_q <= winner;
      if (winner) begin
        is_rd_q        <= m1_read & ~m1_write;
        mem_address    <= m1_address;
        mem_byteenable <= m1_byteenable;
        mem_writedata  <= m1_writedata;
      end else begin
        is_rd_q        <= m0_read & ~m0_write;
        mem_address    <= m0_address;
        mem_byteenable <= m0_byteenable;
        mem_writedata  <= m0_writedata;
      end
    end
  end

`ifndef ARB_M0_PRIORITY_EN
  // Round-robin history; starts at 1 so m0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
    end else if (take) begin
      last_grant_q <= winner;
    end
  end
`endif

  // Memory strobes and master handshakes, all decoded from registered state.
  always_comb begin
    mem_clken        = 1'b1;
    mem_chipselect   = (state_q == ISSUE);
    mem_write        = (state_q == ISSUE) && !is_rd_q;
    m0_waitrequest   = !((state_q == ISSUE) && !owner_q);
    m1_waitrequest   = !((state_q == ISSUE) &&  owner_q);
    m0_readdatavalid = (state_q == RDATA) && !owner_q;
    m1_readdatavalid = (state_q == RDATA) &&  owner_q;
    m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
    m1_readdata      = m1_readdatavalid ? mem_readdata : '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_onchip_mem_arbiter.sv
// ============================================================================
// Module   : tb_onchip_mem_arbiter
// Purpose  : Directed self-checking bench for onchip_mem_arbiter with a
//            behavioural 2048x32 synchronous memory on port s1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] m0_address = '0, m1_address = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [10:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_readdata = '0;

  logic [31:0] mem_arr [0:2047];
  int          wr_cnt_20 = 0;
  int          wr_cnt_21 = 0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // Synchronous memory: q shows the addressed word the cycle after capture.
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) mem_arr[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        if (mem_address == 11'h020) wr_cnt_20 <= wr_cnt_20 + 1;
        if (mem_address == 11'h021) wr_cnt_21 <= wr_cnt_21 + 1;
      end
      mem_readdata <= mem_arr[mem_address];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_wait"}, {30'd0, m1_waitrequest, m0_waitrequest}, 32'h3);
    check_val({tag, "_rdv"}, {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'h0);
    check_val({tag, "_rd0"}, m0_readdata, 32'h0);
    check_val({tag, "_rd1"}, m1_readdata, 32'h0);
    check_val({tag, "_addr"}, {21'd0, mem_address}, 32'h0);
    check_val({tag, "_be"}, {28'd0, mem_byteenable}, 32'h0);
    check_val({tag, "_wd"}, mem_writedata, 32'h0);
    check_val({tag, "_cs_we_ce"}, {29'd0, mem_chipselect, mem_write, mem_clken}, 32'h1);
  endtask

  task automatic drive(input logic m, input logic rd, input logic wr, input logic [10:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    if (!m) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = wd;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = wd;
    end
  endtask

  // One single-word transfer: request at a negedge, accepted one cycle later,
  // read data (if any) two cycles after the request.
  task automatic xfer(input string tag, input logic m, input logic rd, input logic [10:0] a,
                      input logic [3:0] be, input logic [31:0] wd, input logic [31:0] exp_rd);
    @(negedge clk);
    drive(m, rd, !rd, a, be, wd);
    @(negedge clk);
    check_val({tag, "_wait"}, {30'd0, m1_waitrequest, m0_waitrequest}, m ? 32'h1 : 32'h2);
    check_val({tag, "_cmd"}, {19'd0, mem_chipselect, mem_write, mem_address},
              {19'd0, 1'b1, !rd, a});
    @(negedge clk);
    drive(m, 1'b0, 1'b0, a, be, wd);
    if (rd) begin
      check_val({tag, "_rdv"}, {30'd0, m1_readdatavalid, m0_readdatavalid}, m ? 32'h2 : 32'h1);
      check_val({tag, "_data"}, m ? m1_readdata : m0_readdata, exp_rd);
      check_val({tag, "_other0"}, m ? m0_readdata : m1_readdata, 32'h0);
    end else begin
      check_val({tag, "_rdv"}, {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'h0);
      check_val({tag, "_wait2"}, {30'd0, m1_waitrequest, m0_waitrequest}, 32'h3);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_w;
    logic       acc0, acc1;
    int         g;

    // Reset values while reset is held
    #12;
    check_reset_state("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // m0 write then read back
    xfer("m0_wr", 1'b0, 1'b0, 11'h005, 4'hF, 32'hDEADBEEF, 32'h0);
    xfer("m0_rd", 1'b0, 1'b1, 11'h005, 4'hF, 32'h0, 32'hDEADBEEF);

    // Partial write through m1
    xfer("m0_wfull", 1'b0, 1'b0, 11'h010, 4'hF, 32'hFFFFFFFF, 32'h0);
    xfer("m1_wpart", 1'b1, 1'b0, 11'h010, 4'h3, 32'h11223344, 32'h0);
    xfer("m1_rd", 1'b1, 1'b1, 11'h010, 4'hF, 32'h0, 32'hFFFF3344);

    // Read interrupted by reset during RDATA
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 11'h005, 4'hF, 32'h0);
    @(negedge clk);
    check_val("rstrd_wait", {30'd0, m1_waitrequest, m0_waitrequest}, 32'h2);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    #1;
    check_reset_state("async");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("rstrd_norv", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'h0);
    xfer("post_m1_wr", 1'b1, 1'b0, 11'h033, 4'hF, 32'hCAFEF00D, 32'h0);
    xfer("post_m1_rd", 1'b1, 1'b1, 11'h033, 4'hF, 32'h0, 32'hCAFEF00D);

    // Both masters writing continuously from a fresh reset
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wr_cnt_20 = 0;
    wr_cnt_21 = 0;
    drive(1'b0, 1'b0, 1'b1, 11'h020, 4'hF, 32'hA0000000);
    drive(1'b1, 1'b0, 1'b1, 11'h021, 4'hF, 32'hB0000000);
    acc0 = 1'b0;
    acc1 = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      if (acc0) m0_writedata = m0_writedata + 32'd1;
      if (acc1) m1_writedata = m1_writedata + 32'd1;
      g = (i - 1) / 2;
      if (i == 13) exp_w = 2'b01;
      else if (i % 2 == 0) exp_w = 2'b11;
`ifdef ARB_M0_PRIORITY_EN
      else exp_w = 2'b10;
`else
      else exp_w = (g % 2 == 0) ? 2'b10 : 2'b01;
`endif
      check_val($sformatf("rr_wait_%0d", i), {30'd0, m1_waitrequest, m0_waitrequest},
                {30'd0, exp_w});
      acc0 = !m0_waitrequest;
      acc1 = !m1_waitrequest;
      if (i == 12) m0_write = 1'b0;
    end
    @(negedge clk);
    m1_write = 1'b0;
    @(negedge clk);
`ifdef ARB_M0_PRIORITY_EN
    check_val("rr_cnt0", wr_cnt_20, 32'd6);
    check_val("rr_cnt1", wr_cnt_21, 32'd1);
    check_val("rr_mem0", mem_arr[11'h020], 32'hA0000005);
    check_val("rr_mem1", mem_arr[11'h021], 32'hB0000000);
`else
    check_val("rr_cnt0", wr_cnt_20, 32'd3);
    check_val("rr_cnt1", wr_cnt_21, 32'd4);
    check_val("rr_mem0", mem_arr[11'h020], 32'hA0000002);
    check_val("rr_mem1", mem_arr[11'h021], 32'hB0000003);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Two-master arbiter for port s1 of the 2048×32 on-chip memory. Two Avalon-MM masters issue single-word reads and writes. The arbiter grants one master at a time, drives the memory port with registered command signals and returns read data to the owning master with a readdatavalid pulse. It sits between the CPU data master / DMA master and the memory's s1 slave; port s2 remains dedicated.

## Interface
- ADDR_W, 11, word address width (2048 words)
- DATA_W, 32, data width
- BE_W, 4, byteenable width (DATA_W/8)

- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- m0_address / m1_address  in  ADDR_W  master word address
- m0_byteenable / m1_byteenable  in  BE_W  byte lanes for writes
- m0_read / m1_read  in  1  read request, held until accepted
- m0_write / m1_write  in  1  write request, held until accepted
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_waitrequest / m1_waitrequest  out  1  high = not accepted this cycle
- m0_readdata / m1_readdata  out  DATA_W  read data, valid with readdatavalid
- m0_readdatavalid / m1_readdatavalid  out  1  one-cycle read-return strobe
- mem_address  out  ADDR_W  to memory address (registered)
- mem_byteenable  out  BE_W  to memory byteenable (registered)
- mem_writedata  out  DATA_W  to memory writedata (registered)
- mem_chipselect  out  1  memory select, high only in ISSUE
- mem_write  out  1  memory write, high only in ISSUE for writes
- mem_clken  out  1  tied 1
- mem_readdata  in  DATA_W  memory q, valid the cycle after the address is clocked

## Operation
- FSM states: IDLE, ISSUE, RDATA. Registers: owner (1 bit), is_rd, last_grant.
- IDLE, no request: stay in IDLE.
- IDLE, any request (mX_read|mX_write): pick a winner and latch its address, byteenable and writedata into mem_* registers. Set is_rd = read & ~write, set owner, then go to ISSUE.
- Read and write asserted together is illegal; write wins.
- Arbitration: only one requester means it wins. On a tie, the master ≠ last_grant wins. last_grant updates to the winner on the IDLE→ISSUE transition.
- ISSUE: mem_chipselect=1, mem_write=~is_rd. mX_waitrequest=0 for X=owner only, which completes the master's transfer. Next state is RDATA if is_rd, else IDLE.
- RDATA: m{owner}_readdatavalid=1. m{owner}_readdata=mem_readdata; the non-owner's readdata is 0. Next state IDLE.
- mX_waitrequest = ~(state==ISSUE & owner==X), so it is high whenever the master is not being accepted, including when idle.
- Masters must hold their command stable while waitrequest is high. A command dropped after latching is still executed.

## Timing
- Reset values: state=IDLE, last_grant=1 (m0 wins the first tie), mem_address/byteenable/writedata=0, mem_chipselect=0, mem_write=0, both waitrequest=1, both readdatavalid=0, both readdata=0. mem_clken=1 always.
- Request first seen high in cycle N (state IDLE):
  - ISSUE in N+1, with waitrequest low in N+1.
  - Memory captures command at the end of N+1.
  - Read data and readdatavalid in N+2.
- Throughput: write every 2 cycles, read every 3 cycles. Arbitration is evaluated only in IDLE.
- A request arriving during ISSUE/RDATA waits and is evaluated in the next IDLE cycle.
- reset_n low mid-operation: immediate return to IDLE. An outstanding read is dropped with no readdatavalid. A write already clocked into memory is not undone.

## Configuration
- ARB_M0_PRIORITY_EN defined: fixed priority; m0 always wins a tie; last_grant is unused. m1 can starve while m0 requests continuously.
- Not defined: round-robin as described in Operation.

## Test plan
- Reset: assert reset_n=0 mid-cycle -> all outputs at listed reset values asynchronously; mem_clken=1.
- m0 writes 0xDEADBEEF to address 0x005 with BE 0xF, then reads 0x005 -> waitrequest low exactly 1 cycle after each request; readdatavalid 2 cycles after the request with m0_readdata=0xDEADBEEF; m1_readdatavalid stays 0.
- Partial write: memory 0x010=0xFFFFFFFF; m1 writes 0x11223344 with BE 0x3; m1 reads 0x010 -> 0xFFFF3344.
- Both masters request writes continuously from reset -> grants go m0, m1, m0, m1; each grant is one ISSUE cycle 2 cycles apart; no lost or duplicated transfers.
- m0 read issued, reset_n pulsed low during RDATA -> no readdatavalid on either master; next m1 request is granted normally after release.
- With ARB_M0_PRIORITY_EN: both request continuously for 6 transfers -> all granted to m0; m1 is granted on the first IDLE after m0 deasserts.
